// File: rtl/sram_rd_pkg.sv
// Shared widths, aspect-ratio encodings and address/mask helpers for the SRAM read port.
package sram_rd_pkg;

    localparam int unsigned LADDR_W = 15;
    localparam int unsigned WADDR_W = 10;
    localparam int unsigned SUB_W   = 5;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [2:0] {
        CONF_1KX32 = 3'd0,
        CONF_2KX16 = 3'd1,
        CONF_4KX8  = 3'd2,
        CONF_8KX4  = 3'd3,
        CONF_16KX2 = 3'd4,
        CONF_32KX1 = 3'd5
    } conf_e;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [SUB_W-1:0]   sub;
    } addr_split_t;

    // Element mask of width 32>>conf; the extra top bit lets conf 0 yield all-ones.
    function automatic logic [DATA_W-1:0] conf_mask(input logic [2:0] conf);
        logic [DATA_W:0] m;
        m = (33'd1 << (6'd32 >> conf)) - 33'd1;
        return m[DATA_W-1:0];
    endfunction

    function automatic addr_split_t split_addr(input logic [LADDR_W-1:0] laddr,
                                               input logic [2:0]         conf);
        addr_split_t      r;
        logic [LADDR_W-1:0] shifted;
        logic [SUB_W:0]     low;
        shifted = laddr >> conf;
        low     = (6'd1 << conf) - 6'd1;
        r.waddr = shifted[WADDR_W-1:0];
        r.sub   = laddr[SUB_W-1:0] & low[SUB_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_ctrl_if.sv
// Request/response handshake bundle between a read requester and sram_rd_ctrl.
interface sram_rd_ctrl_if;
    import sram_rd_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [LADDR_W-1:0] req_addr;
    logic [2:0]         req_conf;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_addr, req_conf, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_conf, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/sram_rd_rsp_fifo.sv
// Response FIFO: arbitrary depth, pointers wrap modulo DEPTH, push and pop in one cycle even when full.
module sram_rd_rsp_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 33,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));
`endif

endmodule

// File: rtl/sram_rd_ctrl.sv
// SRAM read-port front end: address split, latency-matched conf/sub pipeline, masked response FIFO.
// Optional invalid-conf detection is enabled by defining SRAM_RD_CONF_CHECK_EN.
module sram_rd_ctrl
    import sram_rd_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_rd_ctrl_if.slave      bus,
    output logic               mem_csb,
    output logic [WADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]  mem_dout,
    output logic [2:0]         sh_conf,
    output logic [SUB_W-1:0]   sh_addr,
    input  logic [DATA_W-1:0]  sh_dout
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned LAST  = RD_LAT - 1;

    logic               accept;
    logic               req_err;
    logic [2:0]         conf_eff;
    addr_split_t        split;
    logic               pv    [RD_LAT];
    logic [2:0]         pconf [RD_LAT];
    logic [SUB_W-1:0]   psub  [RD_LAT];
    logic               perr  [RD_LAT];
    int unsigned        inflight;
    logic [CNT_W-1:0]   occ;
    logic               fifo_empty;
    logic               fifo_full;
    logic [DATA_W:0]    push_entry;
    logic [DATA_W:0]    head;
    logic               unused_sinks;

`ifdef SRAM_RD_CONF_CHECK_EN
    assign req_err  = bus.req_conf[2] & bus.req_conf[1];
    assign conf_eff = bus.req_conf;
`else
    assign req_err  = 1'b0;
    assign conf_eff = (bus.req_conf > CONF_32KX1) ? 3'(CONF_32KX1) : bus.req_conf;
`endif

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 32'(pv[i]);
        end
    end

    // Credits cover both queued and in-flight reads, so a push can always land.
    assign bus.req_ready = rst_n && ((32'(occ) + inflight) < RSP_DEPTH);
    assign accept        = bus.req_valid && bus.req_ready;
    assign mem_csb       = !(accept && !req_err);
    assign split         = split_addr(bus.req_addr, conf_eff);
    assign mem_addr      = split.waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pv[i]    <= 1'b0;
                pconf[i] <= '0;
                psub[i]  <= '0;
                perr[i]  <= 1'b0;
            end
        end else begin
            pv[0]    <= accept;
            pconf[0] <= conf_eff;
            psub[0]  <= split.sub;
            perr[0]  <= req_err;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i]    <= pv[i-1];
                pconf[i] <= pconf[i-1];
                psub[i]  <= psub[i-1];
                perr[i]  <= perr[i-1];
            end
        end
    end

    assign sh_conf    = pv[LAST] ? pconf[LAST] : '0;
    assign sh_addr    = pv[LAST] ? psub[LAST]  : '0;
    assign push_entry = perr[LAST] ? {{DATA_W{1'b0}}, 1'b1}
                                   : {sh_dout & conf_mask(pconf[LAST]), 1'b0};

    sram_rd_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pv[LAST]),
        .push_data (push_entry),
        .pop       (bus.rsp_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (occ)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_data  = fifo_empty ? '0 : head[DATA_W:1];
`ifdef SRAM_RD_CONF_CHECK_EN
    assign bus.rsp_err   = !fifo_empty && head[0];
`else
    assign bus.rsp_err   = 1'b0;
`endif

    // mem_dout feeds only the external shifter; fullness is implied by the credit rule.
    assign unused_sinks = ^{mem_dout, head[0], fifo_full};

endmodule

// File: doc/sram_rd_ctrl.md
Name: sram_rd_ctrl

Overview:
Read-port front end for the configurable-aspect-ratio SRAM unit. It accepts logical read requests (valid/ready), splits the logical address into a 10-bit physical word address and a 5-bit sub-word select, and drives the macro. It carries conf and sub-word select down a latency-matched pipeline so they arrive aligned with macro read data at the downstream output shifter. The shifted result is masked and buffered in a small response FIFO with valid/ready.

Parameters:
RD_LAT, 1, macro read latency in cycles (>=1)
RSP_DEPTH, 3, response FIFO entries; must be >= RD_LAT+1, and >= RD_LAT+2 for full throughput

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready at rising clk
req_addr  in  15  logical address (element index)
req_conf  in  3  aspect ratio: 000=1kx32, 001=2kx16, 010=4kx8, 011=8kx4, 100=16kx2, 101=32kx1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready
rsp_data  out  32  element, LSB-aligned, zero above element width
rsp_err  out  1  invalid conf (feature-dependent)
mem_csb  out  1  macro chip select, active low
mem_addr  out  10  macro word address
mem_dout  in  32  macro read data, valid RD_LAT cycles after the sampling edge
sh_conf  out  3  conf aligned with mem_dout, to output shifter
sh_addr  out  5  sub-word select aligned with mem_dout, to output shifter
sh_dout  in  32  shifter result, combinational from mem_dout/sh_conf/sh_addr

Behaviour:
- Address split for conf k in 0..5: mem_addr = req_addr[9+k:k]; sub = req_addr[k-1:0] zero-extended to 5 bits (sub=0 for k=0). Bits of req_addr above bit 9+k are ignored.
- inflight = number of valid pipeline stages; occ = FIFO occupancy.
- req_ready = (occ + inflight < RSP_DEPTH). No combinational path from rsp_ready. Forced 0 while rst_n is low.
- Accept on edge T:
  - mem_csb = !(req_valid && req_ready) combinationally; macro samples at T.
  - The valid, conf, sub and err tags enter an RD_LAT-deep shift pipeline.
  - mem_addr follows req_addr/req_conf combinationally whenever csb is low; it is don't-care otherwise.
- The last pipeline stage drives sh_conf/sh_addr; these are 0 when that stage is invalid.
- At edge T+RD_LAT the FIFO pushes {sh_dout & mask(conf), err}. mask = 2^(32>>conf)-1; mask = all-ones for conf 0.
- Request acceptance to rsp_valid is RD_LAT+1 edges.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full (pop first).
  - Push when full cannot occur because of the credit rule; an assertion checks this.
  - rsp_data/rsp_err come from the head entry and hold stable while rsp_valid && !rsp_ready.
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: responses are returned strictly in request order.
- Reset (asynchronous, any time): all pipeline valids cleared, FIFO emptied, rsp_valid=0, rsp_data=0, rsp_err=0, mem_csb=1, sh_conf=0, sh_addr=0. In-flight reads are discarded; no response is produced for them after reset.

Optional Feature:
SRAM_RD_CONF_CHECK_EN
- Defined:
  - req_conf of 110 or 111 is accepted, but mem_csb stays 1.
  - The request occupies a credit and pipeline slot like a normal read.
  - Its response has rsp_data=0 and rsp_err=1.
- Undefined:
  - conf 110/111 is treated as 101 (32kx1).
  - rsp_err is tied to 0.

Decomposition:
- Package sram_rd_pkg holds:
  - conf encodings CONF_1KX32..CONF_32KX1;
  - widths LADDR_W=15, WADDR_W=10, SUB_W=5;
  - function conf_mask(conf) returning the 32-bit mask;
  - function split_addr(laddr, conf) returning word address and sub select.
- One sub-module: sram_rd_rsp_fifo, a parameterised-depth synchronous FIFO with simultaneous push/pop, count output and async active-low reset.

Test Plan:
- Single read: conf=010, req_addr=0x0123, mem_dout=0xDEADBEEF, bench shifter selects byte 3 (sh_dout=0x000000DE) -> mem_addr=0x048; sh_conf=2 and sh_addr=3 one cycle later; rsp_data=0x000000DE, rsp_valid 2 edges after accept.
- Extreme split: conf=101, req_addr=0x7FFF -> mem_addr=0x3FF, sh_addr=0x1F; sh_dout=0xFFFFFFFF gives rsp_data=0x00000001.
- Streaming: 16 back-to-back conf=000 reads, rsp_ready=1, RD_LAT=1, RSP_DEPTH=3 -> req_ready never drops; 16 responses, one per cycle, in order; data unmasked.
- Backpressure: rsp_ready=0, offer 5 requests -> exactly 3 accepted, req_ready=0 afterward, rsp_data stable. Raise rsp_ready -> 3 ordered responses, then req_ready returns to 1.
- Invalid conf=110 with SRAM_RD_CONF_CHECK_EN -> mem_csb stays 1; rsp_err=1, rsp_data=0; order kept relative to neighbouring valid reads.
- Reset mid-flight: assert rst_n=0 with 1 read in flight and 2 in FIFO -> rsp_valid=0 and mem_csb=1 immediately. After release, no stale responses; a new read completes normally.
